// File: rtl/cf_pwm_dt_pkg.sv
// cf_pwm_dt_pkg
// Shared types and constants for the CF_TMR32 dead-time / gate-drive stage.
//   pwm_state_t  : gate-drive FSM states
//   DT_W_DEFAULT : default width of the dead-time count registers
//   SYNC_STAGES  : flop count of the fault-pin synchronizer
package cf_pwm_dt_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        HI_ON = 3'd1,
        LO_ON = 3'd2,
        DT_HI = 3'd3,
        DT_LO = 3'd4,
        FAULT = 3'd5
    } pwm_state_t;

    localparam int unsigned DT_W_DEFAULT = 8;
    localparam int unsigned SYNC_STAGES  = 2;

endpackage

// File: rtl/cf_pwm_dt_sync.sv
// cf_pwm_dt_sync
// Multi-flop level synchronizer (SYNC_STAGES flops) for an asynchronous input.
// All flops reset to 0.
//   clk   in  : destination clock
//   rst_n in  : asynchronous active-low reset
//   din   in  : asynchronous input
//   dout  out : synchronized copy of din
module cf_pwm_dt_sync
    import cf_pwm_dt_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic dout
);

    logic [SYNC_STAGES-1:0] sync_ff;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_ff <= '0;
        end else begin
            sync_ff <= {sync_ff[SYNC_STAGES-2:0], din};
        end
    end

    assign dout = sync_ff[SYNC_STAGES-1];

endmodule

// File: rtl/cf_pwm_deadtime.sv
// cf_pwm_deadtime
// Complementary high/low gate driver with break-before-make dead time and a
// sticky fault latch, fed by one CF_TMR32 PWM output.
//   CLK           in  : block clock
//   RESETn        in  : asynchronous active-low reset
//   en            in  : channel enable, 0 forces both gates off
//   pwm_in        in  : PWM from timer, synchronous to CLK
//   dt_rise       in  : dead cycles before pwm_hi turns on (gap = dt_rise+1)
//   dt_fall       in  : dead cycles before pwm_lo turns on (gap = dt_fall+1)
//   fault_in      in  : fault request, active high
//   fault_clr     in  : one-cycle pulse, clears the latched fault
//   pwm_hi        out : high-side gate (registered)
//   pwm_lo        out : low-side gate (registered)
//   dt_active     out : 1 while a dead-time gap is counted
//   fault_latched out : sticky fault status
// Build option: define CF_PWM_DT_FAULT_SYNC_EN to pass fault_in through a
// 2-flop synchronizer (for the raw pwm_fault pin); otherwise fault_in is used
// directly and must be synchronous to CLK.
module cf_pwm_deadtime
    import cf_pwm_dt_pkg::*;
#(
    parameter int unsigned DT_W = DT_W_DEFAULT
) (
    input  logic            CLK,
    input  logic            RESETn,
    input  logic            en,
    input  logic            pwm_in,
    input  logic [DT_W-1:0] dt_rise,
    input  logic [DT_W-1:0] dt_fall,
    input  logic            fault_in,
    input  logic            fault_clr,
    output logic            pwm_hi,
    output logic            pwm_lo,
    output logic            dt_active,
    output logic            fault_latched
);

    logic            fault_s;
    logic            pwm_q;
    logic            pwm_edge;
    pwm_state_t      state;
    pwm_state_t      state_n;
    logic [DT_W-1:0] cnt;
    logic [DT_W-1:0] cnt_n;

`ifdef CF_PWM_DT_FAULT_SYNC_EN
    cf_pwm_dt_sync u_fault_sync (
        .clk   (CLK),
        .rst_n (RESETn),
        .din   (fault_in),
        .dout  (fault_s)
    );
`else
    assign fault_s = fault_in;
`endif

    // Edge is seen in the same cycle pwm_in changes.
    assign pwm_edge = (pwm_in != pwm_q);

    // Priority: fault > !en > pwm edge > counter.
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        if (fault_s) begin
            state_n = FAULT;
        end else if (state == FAULT) begin
            if (fault_clr) begin
                state_n = IDLE;
            end
        end else if (!en) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (pwm_in) begin
                        state_n = DT_HI;
                        cnt_n   = dt_rise;
                    end else begin
                        state_n = DT_LO;
                        cnt_n   = dt_fall;
                    end
                end
                HI_ON: begin
                    if (pwm_edge && !pwm_in) begin
                        state_n = DT_LO;
                        cnt_n   = dt_fall;
                    end
                end
                LO_ON: begin
                    if (pwm_edge && pwm_in) begin
                        state_n = DT_HI;
                        cnt_n   = dt_rise;
                    end
                end
                DT_HI: begin
                    // A reversing edge restarts the full gap in the new direction.
                    if (pwm_edge) begin
                        state_n = DT_LO;
                        cnt_n   = dt_fall;
                    end else if (cnt == '0) begin
                        state_n = HI_ON;
                    end else begin
                        cnt_n = cnt - DT_W'(1);
                    end
                end
                DT_LO: begin
                    if (pwm_edge) begin
                        state_n = DT_HI;
                        cnt_n   = dt_rise;
                    end else if (cnt == '0) begin
                        state_n = LO_ON;
                    end else begin
                        cnt_n = cnt - DT_W'(1);
                    end
                end
                default: begin
                    state_n = IDLE;
                end
            endcase
        end
    end

    // Outputs are decoded from the next state so they are registered alongside it.
    always_ff @(posedge CLK or negedge RESETn) begin
        if (!RESETn) begin
            state         <= IDLE;
            cnt           <= '0;
            pwm_q         <= 1'b0;
            pwm_hi        <= 1'b0;
            pwm_lo        <= 1'b0;
            dt_active     <= 1'b0;
            fault_latched <= 1'b0;
        end else begin
            state         <= state_n;
            cnt           <= cnt_n;
            pwm_q         <= pwm_in;
            pwm_hi        <= (state_n == HI_ON);
            pwm_lo        <= (state_n == LO_ON);
            dt_active     <= (state_n == DT_HI) || (state_n == DT_LO);
            fault_latched <= (state_n == FAULT);
        end
    end

endmodule

// File: tb/tb_cf_pwm_deadtime.sv
// Directed bench for cf_pwm_deadtime. Expected output vectors are
// {pwm_hi, pwm_lo, dt_active, fault_latched}.
module tb_cf_pwm_deadtime;

    localparam int unsigned DT_W = 8;
`ifdef CF_PWM_DT_FAULT_SYNC_EN
    localparam int unsigned FLAT = 3;
`else
    localparam int unsigned FLAT = 1;
`endif

    localparam logic [3:0] V_OFF = 4'b0000;
    localparam logic [3:0] V_HI  = 4'b1000;
    localparam logic [3:0] V_LO  = 4'b0100;
    localparam logic [3:0] V_DT  = 4'b0010;
    localparam logic [3:0] V_FLT = 4'b0001;

    logic            CLK = 1'b0;
    logic            RESETn;
    logic            en;
    logic            pwm_in;
    logic [DT_W-1:0] dt_rise;
    logic [DT_W-1:0] dt_fall;
    logic            fault_in;
    logic            fault_clr;
    logic            pwm_hi;
    logic            pwm_lo;
    logic            dt_active;
    logic            fault_latched;

    int n_checks = 0;
    int n_fails  = 0;

    cf_pwm_deadtime #(.DT_W(DT_W)) dut (
        .CLK           (CLK),
        .RESETn        (RESETn),
        .en            (en),
        .pwm_in        (pwm_in),
        .dt_rise       (dt_rise),
        .dt_fall       (dt_fall),
        .fault_in      (fault_in),
        .fault_clr     (fault_clr),
        .pwm_hi        (pwm_hi),
        .pwm_lo        (pwm_lo),
        .dt_active     (dt_active),
        .fault_latched (fault_latched)
    );

    always #5 CLK = ~CLK;

    // Shoot-through guard, sampled on the inactive edge.
    always @(negedge CLK) begin
        n_checks++;
        assert ((pwm_hi & pwm_lo) === 1'b0) else begin
            n_fails++;
            $error("FAIL overlap: pwm_hi=%b pwm_lo=%b, required not both 1", pwm_hi, pwm_lo);
        end
    end

    task automatic tick(input int unsigned n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [3:0] exp);
        logic [3:0] obs;
        obs = {pwm_hi, pwm_lo, dt_active, fault_latched};
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed hi/lo/dt/flt=%b expected %b", tag, obs, exp);
        end
    endtask

    task automatic step(input string tag, input logic [3:0] exp);
        tick(1);
        chk(tag, exp);
    endtask

    initial begin
        RESETn = 1'b0; en = 1'b0; pwm_in = 1'b0;
        dt_rise = 8'd3; dt_fall = 8'd5;
        fault_in = 1'b0; fault_clr = 1'b0;
        #2;
        chk("reset", V_OFF);
        tick(2);
        RESETn = 1'b1;
        step("idle_no_en", V_OFF);

        // Scenario 1: enable with pwm_in high, dt_rise=3 -> 4 gap cycles.
        en = 1'b1; pwm_in = 1'b1;
        for (int i = 0; i < 4; i++) step("s1_gap", V_DT);
        step("s1_hi_on", V_HI);
        step("s1_hi_hold", V_HI);

        // Scenario 2: falling edge, dt_fall=5 -> 6 gap cycles; mid-gap dt change ignored.
        pwm_in = 1'b0;
        step("s2_gap_first", V_DT);
        dt_fall = 8'd1;
        for (int i = 0; i < 5; i++) step("s2_gap", V_DT);
        step("s2_lo_on", V_LO);

        // Scenario 3: dt=0, 50% duty with period 8.
        dt_rise = 8'd0; dt_fall = 8'd0;
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 8; k++) begin
                pwm_in = (k < 4);
                step("s3_pwm", (k % 4 == 0) ? V_DT : ((k < 4) ? V_HI : V_LO));
            end
        end

        // Scenario 4: dt_rise=10, 2-cycle low glitch during DT_HI with dt_fall=0.
        dt_rise = 8'd10;
        pwm_in = 1'b1;
        for (int i = 0; i < 3; i++) step("s4_dt_hi", V_DT);
        pwm_in = 1'b0;
        step("s4_rev_dt_lo", V_DT);
        step("s4_lo_from_reload", V_LO);
        pwm_in = 1'b1;
        for (int i = 0; i < 11; i++) step("s4_full_gap", V_DT);
        step("s4_hi_on", V_HI);

        // Scenario 5: fault in HI_ON, clear handling.
        fault_in = 1'b1;
        for (int i = 0; i < int'(FLAT) - 1; i++) step("s5_sync_lat", V_HI);
        step("s5_fault", V_FLT);
        fault_clr = 1'b1;
        step("s5_clr_ignored", V_FLT);
        fault_clr = 1'b0; fault_in = 1'b0;
        for (int i = 0; i < int'(FLAT); i++) step("s5_sticky", V_FLT);
        fault_in = 1'b1;
        for (int i = 0; i < int'(FLAT) - 1; i++) step("s5_refault", V_FLT);
        fault_clr = 1'b1;
        step("s5_same_cycle", V_FLT);
        fault_clr = 1'b0; fault_in = 1'b0;
        for (int i = 0; i < int'(FLAT); i++) step("s5_release", V_FLT);
        dt_rise = 8'd2;
        fault_clr = 1'b1;
        step("s5_clr_idle", V_OFF);
        fault_clr = 1'b0;
        for (int i = 0; i < 3; i++) step("s5_regap", V_DT);
        step("s5_hi_again", V_HI);

        // Scenario 6: async reset mid DT_LO and mid LO_ON, then en=0.
        dt_fall = 8'd5; pwm_in = 1'b0;
        step("s6_dt_lo", V_DT);
        step("s6_dt_lo2", V_DT);
        #2 RESETn = 1'b0;
        #1 chk("s6_rst_dt_lo", V_OFF);
        dt_fall = 8'd0;
        tick(1);
        RESETn = 1'b1;
        step("s6_rearm_gap", V_DT);
        step("s6_lo_on", V_LO);
        #2 RESETn = 1'b0;
        #1 chk("s6_rst_lo_on", V_OFF);
        tick(1);
        RESETn = 1'b1;
        step("s6_rearm_gap2", V_DT);
        step("s6_lo_on2", V_LO);
        en = 1'b0;
        step("s6_en_off", V_OFF);
        en = 1'b1;
        step("s6_reen_gap", V_DT);
        step("s6_reen_lo", V_LO);

        tick(2);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
